right_shift_rot: RTL and testbench

//   Parameterised right-rotate register. After reset release it captures the

---
 rtl/right_shift_rot_pkg.sv | 7 +
 rtl/right_shift_rot.sv | 42 ++++
 tb/tb_right_shift_rot.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/right_shift_rot_pkg.sv
// Shared constants for the right-rotate ring register.
package right_shift_rot_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MIN_WIDTH     = 2;

endpackage

// File: rtl/right_shift_rot.sv
// Right-rotate ring register: captures the seed `a` once after reset release,
// then rotates the captured word right by one bit on every clock edge.
module right_shift_rot
  import right_shift_rot_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic             r_loaded;
  logic [WIDTH-1:0] w_rot;

  // A one-bit rotate needs at least two bits to be meaningful.
  generate
    if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("right_shift_rot: WIDTH must be >= 2");
    end
  endgenerate

  assign w_rot = {r_q[0], r_q[WIDTH-1:1]};

  // The first edge after release loads the seed; every later edge rotates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q      <= '0;
      r_loaded <= 1'b0;
    end else if (!r_loaded) begin
      r_q      <= a;
      r_loaded <= 1'b1;
    end else begin
      r_q      <= w_rot;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_right_shift_rot.sv
// Self-checking bench for right_shift_rot at WIDTH=4 and WIDTH=8 against a
// rotate-by-edge-count model, plus literal sequence checks.
module tb_right_shift_rot;

  logic       clk;
  logic       rst;
  logic [3:0] a4;
  logic [3:0] q4;
  logic [7:0] a8;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  right_shift_rot #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .a(a4), .q(q4));
  right_shift_rot #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .a(a8), .q(q8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected word after n edges past the load: seed rotated right by n mod w.
  function automatic int rotr(input int v, input int w, input int n);
    int k;
    int mask;
    k    = n % w;
    mask = (1 << w) - 1;
    return ((v >> k) | (v << (w - k))) & mask;
  endfunction

  bit m_loaded = 1'b0;
  int m_n      = 0;
  int m_seed4  = 0;
  int m_seed8  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_loaded = 1'b0;
      m_n      = 0;
    end else if (!m_loaded) begin
      m_loaded = 1'b1;
      m_seed4  = int'(a4);
      m_seed8  = int'(a8);
      m_n      = 0;
    end else begin
      m_n++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: q=%h (t=%0t)", name, act, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_w4", 32'(q4), m_loaded ? 32'(rotr(m_seed4, 4, m_n)) : 32'd0);
      check("model_w8", 32'(q8), m_loaded ? 32'(rotr(m_seed8, 8, m_n)) : 32'd0);
    end
  end

  task automatic step_check(input string name, input logic [3:0] e4, input logic [7:0] e8);
    @(negedge clk);
    #1;
    check({name, "_w4"}, 32'(q4), 32'(e4));
    check({name, "_w8"}, 32'(q8), 32'(e8));
  endtask

  initial begin
    rst    = 1'b0;
    a4     = 4'b1011;
    a8     = 8'h81;
    cmp_en = 1'b1;

    // Reset held across edges: outputs stay clear.
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold_w4", 32'(q4), 32'd0);
    check("reset_hold_w8", 32'(q8), 32'd0);
    #1 rst = 1'b1;

    step_check("load", 4'b1011, 8'h81);
    a4 = 4'b0001;
    a8 = 8'h3C;
    step_check("rot1", 4'b1101, 8'hC0);
    step_check("rot2", 4'b1110, 8'h60);
    step_check("rot3", 4'b0111, 8'h30);
    step_check("rot4", 4'b1011, 8'h18);
    step_check("rot5", 4'b1101, 8'h0C);
    step_check("rot6", 4'b1110, 8'h06);

    // Asynchronous clear between edges, then reload from the new seed.
    #1 rst = 1'b0;
    #1;
    check("async_clr_w4", 32'(q4), 32'd0);
    check("async_clr_w8", 32'(q8), 32'd0);
    a4 = 4'b1000;
    a8 = 8'h01;
    @(negedge clk);
    #2 rst = 1'b1;
    step_check("reload", 4'b1000, 8'h01);
    step_check("rerot1", 4'b0100, 8'h80);
    step_check("rerot2", 4'b0010, 8'h40);
    step_check("rerot3", 4'b0001, 8'h20);
    step_check("rerot4", 4'b1000, 8'h10);

    // Rotation-invariant seeds stay constant.
    @(negedge clk);
    #2 rst = 1'b0;
    a4 = 4'b0000;
    a8 = 8'hFF;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) step_check("inv_a", 4'b0000, 8'hFF);
    @(negedge clk);
    #2 rst = 1'b0;
    a4 = 4'b1111;
    a8 = 8'h00;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) step_check("inv_b", 4'b1111, 8'h00);

    // Random seeds, reset lengths, run lengths and post-load seed churn.
    for (int it = 0; it < 25; it++) begin
      @(negedge clk);
      #2 rst = 1'b0;
      a4 = 4'($urandom);
      a8 = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #2 rst = 1'b1;
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk);
        #2;
        if ($urandom_range(0, 1) == 1) begin
          a4 = 4'($urandom);
          a8 = 8'($urandom);
        end
      end
    end

    @(negedge clk);
    #2 cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
